// File: rtl/rtc_pkg.sv
// rtc_pkg: field layout of the packed TIME/DATE words and calendar helper functions
// shared by the RTC core and its testbench-facing interfaces.
//   time_t : {MERIDIAN, HOUR[4:0], MIN[5:0], SEC[5:0]}  (18 bits)
//   date_t : {YEAR[6:0], MONTH[3:0], DAY[4:0]}          (16 bits)
package rtc_pkg;

    localparam int TIME_W = 18;
    localparam int DATE_W = 16;

    typedef struct packed {
        logic       mer;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } time_t;

    typedef struct packed {
        logic [6:0] year;
        logic [3:0] month;
        logic [4:0] day;
    } date_t;

    // Years are 2000+year, so every fourth year including 2000 is a leap year.
    function automatic logic is_leap(input logic [6:0] year);
        return year[1:0] == 2'd0;
    endfunction

    function automatic logic [4:0] dim(input logic [3:0] month, input logic [6:0] year);
        case (month)
            4'd2:                    return is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    // Returns {meridian, hour12}; hour 0 and 12 both show as 12.
    function automatic logic [5:0] to_12h(input logic [4:0] hour24);
        logic       pm;
        logic [4:0] h;
        pm = hour24 >= 5'd12;
        h  = pm ? hour24 - 5'd12 : hour24;
        return {pm, (h == 5'd0) ? 5'd12 : h};
    endfunction

    function automatic logic [4:0] from_12h(input logic [4:0] hour12, input logic pm);
        return ((hour12 == 5'd12) ? 5'd0 : hour12) + (pm ? 5'd12 : 5'd0);
    endfunction

endpackage

// File: rtl/rtc_tick_div.sv
// rtc_tick_div: seconds prescaler; TICK is high in the cycle the count sits at
// TICKS_PER_SEC-1 while RUN is high.
//   CLK, RESETN (sync, active-low)
//   RUN  : count enable; the count holds while low
//   CLR  : clear the count and suppress TICK this cycle
//   TICK : one cycle per second of RUN time
module rtc_tick_div #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int CNT_W         = 10
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic RUN,
    input  logic CLR,
    output logic TICK
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        TICK  = RUN && !CLR && (cnt_q == LAST);
        cnt_d = (CLR || TICK) ? '0 : RUN ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: HH:MM:SS + leap-aware calendar with validated load and 12h/24h output.
//   CLK, RESETN (sync, active-low)
//   RUN       : advance time;  MODE_12H : 12h format for OUT_TIME and LOAD_TIME decode
//   LOAD      : load request with LOAD_TIME / LOAD_DATE; answered by LOAD_OK / LOAD_ERR
//   OUT_TIME  : {MERIDIAN, HOUR, MIN, SEC};  OUT_DATE : {YEAR, MONTH, DAY}
//   SEC_PULSE : one cycle per seconds increment;  DAY_PULSE : one cycle at midnight
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int YEAR_RST      = 16,
    parameter int CNT_W         = 10
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              RUN,
    input  logic              MODE_12H,
    input  logic              LOAD,
    input  logic [TIME_W-1:0] LOAD_TIME,
    input  logic [DATE_W-1:0] LOAD_DATE,
    output logic              LOAD_OK,
    output logic              LOAD_ERR,
    output logic [TIME_W-1:0] OUT_TIME,
    output logic [DATE_W-1:0] OUT_DATE,
    output logic              SEC_PULSE,
    output logic              DAY_PULSE
);

    time_t       lt;
    date_t       ld;
    logic        hour_ok, load_valid, load_ok, tick, step;
    logic        sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;
    logic [4:0]  load_hour;
    logic [5:0]  sec_q, sec_d, min_q, min_d;
    logic [4:0]  hour_q, hour_d, day_q, day_d;
    logic [3:0]  mon_q, mon_d;
    logic [6:0]  year_q, year_d;
    logic [TIME_W-1:0] out_time_q, out_time_d;
    logic [DATE_W-1:0] out_date_q;
    logic        sec_pulse_q, day_pulse_q, ok_q, err_q;

    assign lt = LOAD_TIME;
    assign ld = LOAD_DATE;

    always_comb begin
        hour_ok    = MODE_12H ? (lt.hour >= 5'd1 && lt.hour <= 5'd12) : (lt.hour <= 5'd23);
        load_valid = hour_ok && lt.min <= 6'd59 && lt.sec <= 6'd59 &&
                     ld.month >= 4'd1 && ld.month <= 4'd12 &&
                     ld.day >= 5'd1 && ld.day <= dim(ld.month, ld.year) && ld.year <= 7'd99;
        load_ok    = LOAD && load_valid;
        load_hour  = MODE_12H ? from_12h(lt.hour, lt.mer) : lt.hour;
    end

    // Only an accepted load restarts the prescaler; any load swallows a coincident tick
    // so that LOAD_OK/LOAD_ERR never coincide with SEC_PULSE.
    rtc_tick_div #(.TICKS_PER_SEC(TICKS_PER_SEC), .CNT_W(CNT_W)) u_div (
        .CLK   (CLK),
        .RESETN(RESETN),
        .RUN   (RUN),
        .CLR   (load_ok),
        .TICK  (tick)
    );

    assign step = tick && !LOAD;

    always_comb begin
        sec_wrap  = sec_q == 6'd59;
        min_wrap  = sec_wrap && min_q == 6'd59;
        hour_wrap = min_wrap && hour_q == 5'd23;
        day_wrap  = hour_wrap && day_q == dim(mon_q, year_q);
        mon_wrap  = day_wrap && mon_q == 4'd12;
        sec_d  = load_ok ? lt.sec  : !step ? sec_q  : sec_wrap ? 6'd0 : sec_q + 6'd1;
        min_d  = load_ok ? lt.min  : !(step && sec_wrap) ? min_q : min_wrap ? 6'd0 : min_q + 6'd1;
        hour_d = load_ok ? load_hour : !(step && min_wrap) ? hour_q : hour_wrap ? 5'd0 : hour_q + 5'd1;
        day_d  = load_ok ? ld.day  : !(step && hour_wrap) ? day_q : day_wrap ? 5'd1 : day_q + 5'd1;
        mon_d  = load_ok ? ld.month : !(step && day_wrap) ? mon_q : mon_wrap ? 4'd1 : mon_q + 4'd1;
        year_d = load_ok ? ld.year : !(step && mon_wrap) ? year_q : (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
        out_time_d = {MODE_12H ? to_12h(hour_q) : {1'b0, hour_q}, min_q, sec_q};
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= 5'd1;
            mon_q       <= 4'd1;
            year_q      <= 7'(YEAR_RST);
            out_time_q  <= {MODE_12H ? to_12h(5'd0) : 6'd0, 12'd0};
            out_date_q  <= {7'(YEAR_RST), 4'd1, 5'd1};
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            mon_q       <= mon_d;
            year_q      <= year_d;
            out_time_q  <= out_time_d;
            out_date_q  <= {year_q, mon_q, day_q};
            sec_pulse_q <= step;
            day_pulse_q <= step && hour_wrap;
            ok_q        <= load_ok;
            err_q       <= LOAD && !load_valid;
        end
    end

    assign OUT_TIME  = out_time_q;
    assign OUT_DATE  = out_date_q;
    assign SEC_PULSE = sec_pulse_q;
    assign DAY_PULSE = day_pulse_q;
    assign LOAD_OK   = ok_q;
    assign LOAD_ERR  = err_q;

endmodule
